// File: rtl/serial_digit_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_digit_adder_pkg
//   Shared definitions for the digit-serial adder/subtractor: controller state
//   encoding and a helper that sizes the digit counter.
// ---------------------------------------------------------------------------
package serial_digit_adder_pkg;

   // Encoding values are kept identical to the legacy include file so that
   // waveform decoders and any external state probes remain valid.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // One extra bit over $clog2(n) so the counter can step past the last digit
   // index without wrapping, which also keeps n == 1 at a legal 1-bit width.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/serial_digit_adder_digit.sv
// ---------------------------------------------------------------------------
// digit_adder
//   Combinational DIGIT-bit adder slice used by serial_digit_adder.
//   Ports:
//     a, b      in  DIGIT  digit operands
//     ci        in  1      carry into bit 0
//     s         out DIGIT  digit sum
//     co        out 1      carry out of bit DIGIT-1
//     c_msb_in  out 1      carry into bit DIGIT-1 (for signed overflow)
// ---------------------------------------------------------------------------
module digit_adder #(
   parameter int unsigned DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             ci,
   output logic [DIGIT-1:0] s,
   output logic             co,
   output logic             c_msb_in
);

   logic [DIGIT:0] full;

   // The full-adder ripple is written as a single DIGIT+1 bit add; the carry
   // into the top bit is recovered from sum = a ^ b ^ carry_in at that bit.
   assign full     = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};
   assign s        = full[DIGIT-1:0];
   assign co       = full[DIGIT];
   assign c_msb_in = full[DIGIT-1] ^ a[DIGIT-1] ^ b[DIGIT-1];

endmodule

// File: rtl/serial_digit_adder.sv
// ---------------------------------------------------------------------------
// serial_digit_adder
//   Multi-cycle WIDTH-bit adder/subtractor that processes DIGIT bits per
//   clock, carrying between digits in a register. Operands are captured on an
//   accepted start; the result is flagged by a one-cycle done pulse and then
//   held until the next accepted start.
//   Ports:
//     clk    in   1      rising-edge clock
//     rst    in   1      synchronous active-high reset
//     start  in   1      request, sampled only while busy == 0
//     sub    in   1      0: a+b+cin, 1: a-b (as a+~b+1, cin ignored)
//     a, b   in   WIDTH  operands, captured on accept
//     cin    in   1      carry-in, captured on accept (add mode only)
//     busy   out  1      digits being processed
//     done   out  1      one-cycle pulse, result valid
//     sum    out  WIDTH  result modulo 2^WIDTH
//     cout   out  1      carry out of the MSB (sub: 1 = no borrow)
//     ovf    out  1      two's-complement signed overflow
// ---------------------------------------------------------------------------
module serial_digit_adder
   import serial_digit_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned N  = WIDTH / DIGIT;
   localparam int unsigned CW = cnt_width(N);

   if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
      $error("serial_digit_adder: WIDTH (%0d) must be a positive multiple of DIGIT (%0d)",
             WIDTH, DIGIT);
   end

   state_t           state_q;
   state_t           state_d;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;

   logic             accept;
   logic             last;
   logic [31:0]      base;
   logic [DIGIT-1:0] dig_a;
   logic [DIGIT-1:0] dig_b;
   logic [DIGIT-1:0] dig_s;
   logic             dig_co;
   logic             dig_msb_in;

   // Start is only honoured outside RUN, i.e. in IDLE or in the DONE cycle.
   assign accept = start && (state_q != ST_RUN);
   assign last   = (cnt_q == CW'(N - 1));
   assign base   = 32'(cnt_q) * DIGIT;

   // Digit select; only meaningful while in RUN, when cnt_q < N.
   always_comb begin
      dig_a = '0;
      dig_b = '0;
      if (state_q == ST_RUN) begin
         dig_a = a_q[base +: DIGIT];
         dig_b = b_q[base +: DIGIT];
      end
   end

   digit_adder #(
      .DIGIT (DIGIT)
   ) u_digit (
      .a        (dig_a),
      .b        (dig_b),
      .ci       (carry_q),
      .s        (dig_s),
      .co       (dig_co),
      .c_msb_in (dig_msb_in)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept) state_d = ST_RUN;
         ST_RUN:  if (last)   state_d = ST_DONE;
         ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            // Subtraction is folded into the add path: a + ~b + 1.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            cnt_q   <= '0;
         end else if (state_q == ST_RUN) begin
            sum_q[base +: DIGIT] <= dig_s;
            carry_q              <= dig_co;
            cnt_q                <= cnt_q + 1'b1;
            if (last) begin
               cout_q <= dig_co;
               ovf_q  <= dig_msb_in ^ dig_co;
            end
         end
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_digit_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_digit_adder
//   Scoreboard bench for serial_digit_adder. The main instance uses
//   WIDTH=16/DIGIT=4; two extra instances cover DIGIT=16 and DIGIT=1.
// ---------------------------------------------------------------------------
module tb_serial_digit_adder;

   localparam int NDIG = 4;   // 16 / 4 digit cycles for the main instance

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      int          acc;
   } exp_t;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        start = 1'b0;
   logic        sub   = 1'b0;
   logic        cin   = 1'b0;
   logic [15:0] a     = '0;
   logic [15:0] b     = '0;
   logic        busy, done, cout, ovf;
   logic [15:0] sum;

   logic        s_start = 1'b0;
   logic        w_busy, w_done, w_cout, w_ovf;
   logic [15:0] w_sum;
   logic        n_busy, n_done, n_cout, n_ovf;
   logic [15:0] n_sum;

   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;
   exp_t sb[$];

   serial_digit_adder #(.WIDTH(16), .DIGIT(4)) dut (
      .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
   );

   serial_digit_adder #(.WIDTH(16), .DIGIT(16)) dut_w (
      .clk(clk), .rst(rst), .start(s_start), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(w_busy), .done(w_done), .sum(w_sum), .cout(w_cout), .ovf(w_ovf)
   );

   serial_digit_adder #(.WIDTH(16), .DIGIT(1)) dut_n (
      .clk(clk), .rst(rst), .start(s_start), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(n_busy), .done(n_done), .sum(n_sum), .cout(n_cout), .ovf(n_ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the operands.
   function automatic exp_t model(input logic [15:0] ia, input logic [15:0] ib,
                                  input logic ic, input logic is);
      exp_t        e;
      int          r;
      logic [16:0] full;
      if (is) begin
         full   = {1'b0, ia} - {1'b0, ib};
         e.sum  = full[15:0];
         e.cout = (ia >= ib);
         r      = int'($signed(ia)) - int'($signed(ib));
      end else begin
         full   = {1'b0, ia} + {1'b0, ib} + 17'(ic);
         e.sum  = full[15:0];
         e.cout = full[16];
         r      = int'($signed(ia)) + int'($signed(ib)) + int'(ic);
      end
      e.ovf = (r > 32767) || (r < -32768);
      e.acc = 0;
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest outstanding request.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && done) begin
         if (sb.size() == 0) begin
            chk("spurious done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("result {ovf,cout,sum}", {14'd0, ovf, cout, sum}, {14'd0, e.ovf, e.cout, e.sum});
            chk("done latency", 32'(cyc - e.acc), 32'(NDIG));
         end
      end
   end

   // Present operands with start high until accepted; hold keeps start high
   // afterwards so the following call can be accepted back-to-back.
   task automatic issue(input logic [15:0] ia, input logic [15:0] ib,
                        input logic ic, input logic is, input logic hold);
      exp_t e;
      @(negedge clk);
      a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
      for (int k = 0; k < 100 && busy; k++) @(negedge clk);
      if (busy) begin
         chk("accept timeout", 32'd1, 32'd0);
         start = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      e     = model(ia, ib, ic, is);
      e.acc = cyc;
      sb.push_back(e);
      if (!hold) begin
         @(negedge clk);
         start = 1'b0;
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
      chk("outstanding results after drain", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat_w;
      int lat_n;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy/done", {30'd0, busy, done}, 32'd0);
      chk("reset sum/cout/ovf", {14'd0, sum, cout, ovf}, 32'd0);
      rst = 1'b0;

      // Directed cases
      issue(16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0);
      drain();
      issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      issue(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
      drain();

      // Start held through RUN with changing operands, accepted in DONE
      issue(16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b1);
      issue(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0);
      drain();

      // Isolated start pulse mid-RUN must be ignored
      issue(16'h00FF, 16'h0F01, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      a = 16'hAAAA; b = 16'h5555; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();

      // Reset at cnt==2 abandons the operation
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      sb.delete();
      @(negedge clk);
      chk("mid-op reset busy/done", {30'd0, busy, done}, 32'd0);
      chk("mid-op reset sum", {16'd0, sum}, 32'd0);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      drain();

      // DIGIT=16 and DIGIT=1 instances
      @(negedge clk);
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b0; s_start = 1'b1;
      @(posedge clk);
      #1;
      s_start = 1'b0;
      lat_w = -1;
      lat_n = -1;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if (w_done && lat_w < 0) begin
            lat_w = k;
            chk("DIGIT=16 {cout,sum}", {15'd0, w_cout, w_sum}, {15'd0, 1'b1, 16'hFFFF});
         end
         if (n_done && lat_n < 0) begin
            lat_n = k;
            chk("DIGIT=1 {cout,sum}", {15'd0, n_cout, n_sum}, {15'd0, 1'b1, 16'hFFFF});
         end
      end
      chk("DIGIT=16 latency", 32'(lat_w), 32'd1);
      chk("DIGIT=1 latency", 32'(lat_n), 32'd16);

      // Randomised operands, modes and gaps
      for (int i = 0; i < 1000; i++) begin
         logic hold;
         hold = (i != 999) && ($urandom_range(0, 1) == 1);
         issue(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), hold);
         if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drain();
      repeat (6) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
